// File: rtl/input_conditioner_defs.sv
// Shared constants and parameter-normalising helpers for the input conditioner.
package input_conditioner_defs;

  localparam int unsigned MIN_SYNC_STAGES  = 2;
  localparam int unsigned DEBOUNCE_SWITCH  = 50000;
  localparam int unsigned DEBOUNCE_DIGITAL = 1;

  function automatic int unsigned eff_sync_stages(input int unsigned stages);
    return (stages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : stages;
  endfunction

  function automatic int unsigned eff_debounce(input int unsigned cycles);
    return (cycles == 0) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioner channel: synchroniser, debounce counter, edge pulses and
// sticky interrupt-pending bit.
module input_conditioner_ch
  import input_conditioner_defs::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1,
  parameter logic        INIT_VALUE      = 1'b0
) (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  input  logic irq_mask,
  input  logic irq_edge,
  input  logic irq_clear,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic irq_pending
);

  localparam int unsigned      STAGES = eff_sync_stages(SYNC_STAGES);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(eff_debounce(DEBOUNCE_CYCLES) - 1);

  logic [STAGES-1:0] sync;
  logic              s;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              dout_next;
  logic              rise_next;
  logic              fall_next;
  logic              set;

  assign s = sync[STAGES-1];

  always_comb begin
    dout_next = dout;
    cnt_next  = '0;
    if (s != dout) begin
      if (cnt == LAST) dout_next = s;
      else             cnt_next  = cnt + CNT_W'(1);
    end
  end

  assign rise_next = dout_next & ~dout;
  assign fall_next = ~dout_next & dout;
  // A set in the same cycle as a clear wins so no event is dropped.
  assign set       = irq_mask & (irq_edge ? rise_next : fall_next);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync        <= {STAGES{INIT_VALUE}};
      dout        <= INIT_VALUE;
      cnt         <= '0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      sync        <= {sync[STAGES-2:0], din};
      dout        <= dout_next;
      cnt         <= cnt_next;
      rise        <= rise_next;
      fall        <= fall_next;
      irq_pending <= set | (irq_pending & ~irq_clear);
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// N-channel input conditioner: per-channel sync/debounce/edge/pending logic
// plus the masked interrupt OR-reduction.
module input_conditioner
  import input_conditioner_defs::*;
#(
  parameter int unsigned          CHANNELS        = 8,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          CNT_W           = 16,
  parameter int unsigned          DEBOUNCE_CYCLES = 1,
  parameter logic [CHANNELS-1:0]  INIT_VALUE      = '0
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [CHANNELS-1:0] din,
  input  logic [CHANNELS-1:0] irq_mask,
  input  logic [CHANNELS-1:0] irq_edge,
  input  logic [CHANNELS-1:0] irq_clear,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] irq_pending,
  output logic                irq
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT_VALUE      (INIT_VALUE[i])
    ) u_ch (
      .clk         (clk),
      .nreset      (nreset),
      .din         (din[i]),
      .irq_mask    (irq_mask[i]),
      .irq_edge    (irq_edge[i]),
      .irq_clear   (irq_clear[i]),
      .dout        (dout[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .irq_pending (irq_pending[i])
    );
  end

  assign irq = |(irq_pending & irq_mask);

endmodule
